// File: rtl/alu_lockstep_checker_pkg.sv
// ---------------------------------------------------------------------------
// alu_lockstep_checker_pkg
//   Shared constants for the lockstep ALU checker: lane opcodes, checker FSM
//   state encodings, lane count and the width of the consecutive-mismatch
//   counter.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package alu_lockstep_checker_pkg;

   // Lane opcodes
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // Checker FSM state encodings (visible on state_o)
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_FAULT = 2'b10;

   // Two redundant lanes compared against each other
   localparam int LANES = 2;

   // Consecutive-mismatch counter width; THRESH tops out at 255
   localparam int CONSEC_W = 8;

endpackage

// File: rtl/alu_lockstep_checker_alu_lane.sv
// ---------------------------------------------------------------------------
// alu_lane
//   Purely combinational single-lane ALU used by the lockstep checker.
//   Ports:
//     a, b    : WIDTH-bit operands
//     sel     : opcode (ADD, SUB, AND, XOR)
//     result  : WIDTH-bit result (modulo 2^WIDTH)
//     carry   : ADD carry-out, SUB borrow (a < b), 0 for logic ops
// ---------------------------------------------------------------------------
module alu_lane
   import alu_lockstep_checker_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] dif_ext;

   // One extra bit: MSB of the sum is the carry, MSB of the zero-extended
   // difference is set exactly when a < b, i.e. the borrow.
   assign sum_ext = {1'b0, a} + {1'b0, b};
   assign dif_ext = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (sel)
         OP_ADD: begin
            result = sum_ext[WIDTH-1:0];
            carry  = sum_ext[WIDTH];
         end
         OP_SUB: begin
            result = dif_ext[WIDTH-1:0];
            carry  = dif_ext[WIDTH];
         end
         OP_AND: result = a & b;
         OP_XOR: result = a ^ b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_lockstep_checker.sv
// ---------------------------------------------------------------------------
// alu_lockstep_checker
//   Two redundant ALU lanes in a two-stage pipeline whose registered results
//   are compared every valid cycle. Mismatches are counted (saturating total
//   and a consecutive run counter); a run of THRESH consecutive mismatches
//   latches the FAULT state until clear_i.
//   Ports:
//     wb_clk_i, wb_rst_ni      : clock, asynchronous active-low reset
//     en_i                     : checker enable (gates operand capture, FSM)
//     clear_i                  : synchronous clear of counters / FAULT exit
//     in_valid_i               : qualifies the operand set
//     a0_i,b0_i,sel0_i         : lane 0 operands / opcode
//     a1_i,b1_i,sel1_i         : lane 1 operands / opcode
//     out0_o,out1_o            : registered lane results
//     carry0_o,carry1_o        : registered lane carry/borrow
//     diff_o, carry_diff_o     : XOR of the two lanes' results / carries
//     out_valid_o              : qualifies all result outputs
//     mismatch_o               : pulse for each valid mismatching result
//     err_count_o              : saturating total mismatch count
//     fault_o, state_o         : FAULT flag and FSM state encoding
// ---------------------------------------------------------------------------
module alu_lockstep_checker
   import alu_lockstep_checker_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int CNT_W  = 8,
   parameter int THRESH = 3
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             en_i,
   input  logic             clear_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] a0_i,
   input  logic [WIDTH-1:0] b0_i,
   input  logic [WIDTH-1:0] a1_i,
   input  logic [WIDTH-1:0] b1_i,
   input  logic [1:0]       sel0_i,
   input  logic [1:0]       sel1_i,
   output logic [WIDTH-1:0] out0_o,
   output logic [WIDTH-1:0] out1_o,
   output logic             carry0_o,
   output logic             carry1_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             carry_diff_o,
   output logic             out_valid_o,
   output logic             mismatch_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic             fault_o,
   output logic [1:0]       state_o
);

   localparam logic [CNT_W-1:0]    ERR_MAX  = '1;
   localparam logic [CONSEC_W-1:0] THRESH_C = CONSEC_W'(THRESH);

   // ------------------------------------------------------------------
   // Lane input fan-in, so both lanes can be built by one generate loop
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] a_in   [LANES];
   logic [WIDTH-1:0] b_in   [LANES];
   logic [1:0]       sel_in [LANES];

   assign a_in[0]   = a0_i;
   assign a_in[1]   = a1_i;
   assign b_in[0]   = b0_i;
   assign b_in[1]   = b1_i;
   assign sel_in[0] = sel0_i;
   assign sel_in[1] = sel1_i;

   // A disabled checker treats in_valid_i as low; data already in the
   // pipe keeps moving so the last results still appear.
   logic accept;
   logic v1_reg;
   logic v2_reg;

   assign accept = en_i & in_valid_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         v1_reg <= 1'b0;
         v2_reg <= 1'b0;
      end else begin
         v1_reg <= accept;
         v2_reg <= v1_reg;
      end
   end

   // ------------------------------------------------------------------
   // Per-lane pipeline: stage 1 holds operands, stage 2 holds results.
   // Both stages only load on valid data, so bubbles leave the outputs
   // holding their previous values.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WIDTH-1:0] a_reg;
         logic [WIDTH-1:0] b_reg;
         logic [1:0]       sel_reg;
         logic [WIDTH-1:0] res_next;
         logic             carry_next;
         logic [WIDTH-1:0] out_reg;
         logic             carry_reg;

         always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
               a_reg   <= '0;
               b_reg   <= '0;
               sel_reg <= OP_ADD;
            end else if (accept) begin
               a_reg   <= a_in[gi];
               b_reg   <= b_in[gi];
               sel_reg <= sel_in[gi];
            end
         end

         alu_lane #(
            .WIDTH (WIDTH)
         ) u_alu_lane (
            .a      (a_reg),
            .b      (b_reg),
            .sel    (sel_reg),
            .result (res_next),
            .carry  (carry_next)
         );

         always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
               out_reg   <= '0;
               carry_reg <= 1'b0;
            end else if (v1_reg) begin
               out_reg   <= res_next;
               carry_reg <= carry_next;
            end
         end
      end
   endgenerate

   assign out0_o       = g_lane[0].out_reg;
   assign out1_o       = g_lane[1].out_reg;
   assign carry0_o     = g_lane[0].carry_reg;
   assign carry1_o     = g_lane[1].carry_reg;
   assign diff_o       = out0_o ^ out1_o;
   assign carry_diff_o = carry0_o ^ carry1_o;
   assign out_valid_o  = v2_reg;

   // Compare straight off the result registers so the pulse lines up
   // with out_valid_o.
   logic mismatch;
   assign mismatch   = v2_reg & ((|diff_o) | carry_diff_o);
   assign mismatch_o = mismatch;

   // ------------------------------------------------------------------
   // Counters and FSM
   // ------------------------------------------------------------------
   logic [1:0]          state_reg,  state_next;
   logic [CNT_W-1:0]    err_reg,    err_next;
   logic [CONSEC_W-1:0] consec_reg, consec_next;
   logic                active;
   logic                hit_thresh;

   assign active = (state_reg != ST_IDLE);

   // clear_i beats a coincident mismatch; counting is frozen in IDLE and
   // bubbles leave the consecutive run untouched.
   always_comb begin
      err_next    = err_reg;
      consec_next = consec_reg;
      if (clear_i) begin
         err_next    = '0;
         consec_next = '0;
      end else if (active) begin
         if (mismatch) begin
            if (err_reg != ERR_MAX) begin
               err_next = err_reg + 1'b1;
            end
            if (consec_reg != THRESH_C) begin
               consec_next = consec_reg + 1'b1;
            end
         end else if (v2_reg) begin
            consec_next = '0;
         end
      end
   end

   assign hit_thresh = !clear_i && active && mismatch && (consec_next == THRESH_C);

   // A threshold hit takes priority over a simultaneous disable so a
   // fault is never lost by dropping en_i on the same cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (en_i) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (hit_thresh) begin
               state_next = ST_FAULT;
            end else if (!en_i) begin
               state_next = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (clear_i) begin
               state_next = en_i ? ST_RUN : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_reg  <= ST_IDLE;
         err_reg    <= '0;
         consec_reg <= '0;
      end else begin
         state_reg  <= state_next;
         err_reg    <= err_next;
         consec_reg <= consec_next;
      end
   end

   assign err_count_o = err_reg;
   assign fault_o     = (state_reg == ST_FAULT);
   assign state_o     = state_reg;

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// ---------------------------------------------------------------------------
// tb_alu_lockstep_checker
//   Self-checking bench: a directed vector table, hand-written multi-cycle
//   sequences, and randomized traffic compared each cycle against a
//   behavioural model. A second instance with CNT_W=2 shares the stimulus
//   to exercise error-counter saturation.
// ---------------------------------------------------------------------------
module tb_alu_lockstep_checker;

   localparam int W      = 4;
   localparam int M      = 1 << W;
   localparam int THRESH = 3;
   localparam int EMAX   = 255;
   localparam int EMAX_S = 3;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         clr;
   logic         in_valid;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   sel0, sel1;

   logic [W-1:0] out0, out1, diff;
   logic         carry0, carry1, carry_diff, out_valid, mismatch, fault;
   logic [7:0]   err_count;
   logic [1:0]   state;

   logic [W-1:0] out0_s, out1_s, diff_s;
   logic         carry0_s, carry1_s, carry_diff_s, out_valid_s, mismatch_s, fault_s;
   logic [1:0]   err_count_s;
   logic [1:0]   state_s;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   alu_lockstep_checker #(.WIDTH(W), .CNT_W(8), .THRESH(THRESH)) u_dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .clear_i(clr),
      .in_valid_i(in_valid), .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
      .sel0_i(sel0), .sel1_i(sel1), .out0_o(out0), .out1_o(out1),
      .carry0_o(carry0), .carry1_o(carry1), .diff_o(diff),
      .carry_diff_o(carry_diff), .out_valid_o(out_valid),
      .mismatch_o(mismatch), .err_count_o(err_count), .fault_o(fault),
      .state_o(state)
   );

   alu_lockstep_checker #(.WIDTH(W), .CNT_W(2), .THRESH(THRESH)) u_dut_sat (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .clear_i(clr),
      .in_valid_i(in_valid), .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
      .sel0_i(sel0), .sel1_i(sel1), .out0_o(out0_s), .out1_o(out1_s),
      .carry0_o(carry0_s), .carry1_o(carry1_s), .diff_o(diff_s),
      .carry_diff_o(carry_diff_s), .out_valid_o(out_valid_s),
      .mismatch_o(mismatch_s), .err_count_o(err_count_s), .fault_o(fault_s),
      .state_o(state_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   typedef struct {
      bit v;
      int a0, b0, a1, b1, s0, s1;
   } set_t;

   set_t q[$];          // accepted operand sets still travelling to the output
   bit   m_valid;
   int   m_o0, m_o1, m_c0, m_c1;
   int   m_state;       // 0 idle, 1 run, 2 fault
   int   m_err, m_err_s, m_consec;

   function automatic void ref_alu(input int a, input int b, input int sel,
                                   output int r, output int c);
      case (sel)
         0: begin r = (a + b) % M;     c = (a + b >= M) ? 1 : 0; end
         1: begin r = (a - b + M) % M; c = (a < b) ? 1 : 0;      end
         2: begin r = a & b;           c = 0;                    end
         default: begin r = a ^ b;     c = 0;                    end
      endcase
   endfunction

   function automatic void model_reset();
      q.delete();
      m_valid = 0; m_o0 = 0; m_o1 = 0; m_c0 = 0; m_c1 = 0;
      m_state = 0; m_err = 0; m_err_s = 0; m_consec = 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all();
      bit e_mm;
      e_mm = m_valid && ((m_o0 != m_o1) || (m_c0 != m_c1));
      chk("out_valid",   32'(out_valid),  32'(m_valid));
      chk("out0",        32'(out0),       32'(m_o0));
      chk("out1",        32'(out1),       32'(m_o1));
      chk("carry0",      32'(carry0),     32'(m_c0));
      chk("carry1",      32'(carry1),     32'(m_c1));
      chk("diff",        32'(diff),       32'(m_o0 ^ m_o1));
      chk("carry_diff",  32'(carry_diff), 32'(m_c0 ^ m_c1));
      chk("mismatch",    32'(mismatch),   32'(e_mm));
      chk("err_count",   32'(err_count),  32'(m_err));
      chk("fault",       32'(fault),      32'(m_state == 2));
      chk("state",       32'(state),      32'(m_state));
      chk("err_count_s", 32'(err_count_s), 32'(m_err_s));
      chk("out_valid_s", 32'(out_valid_s), 32'(m_valid));
   endtask

   // One clock: predict from current inputs/model, clock, compare.
   task automatic step();
      set_t cur, s;
      bit   mm;
      int   n_err, n_err_s, n_con, n_state, n_o0, n_o1, n_c0, n_c1;
      bit   n_valid;
      mm      = m_valid && ((m_o0 != m_o1) || (m_c0 != m_c1));
      n_err   = m_err;
      n_err_s = m_err_s;
      n_con   = m_consec;
      n_state = m_state;
      if (clr) begin
         n_err = 0; n_err_s = 0; n_con = 0;
      end else if (m_state != 0 && mm) begin
         n_err   = (m_err   < EMAX)   ? m_err + 1   : EMAX;
         n_err_s = (m_err_s < EMAX_S) ? m_err_s + 1 : EMAX_S;
         n_con   = (m_consec < THRESH) ? m_consec + 1 : THRESH;
      end else if (m_state != 0 && m_valid) begin
         n_con = 0;
      end
      case (m_state)
         0: n_state = en ? 1 : 0;
         1: begin
            if (!clr && mm && n_con == THRESH) n_state = 2;
            else if (!en)                      n_state = 0;
         end
         default: if (clr) n_state = en ? 1 : 0;
      endcase

      cur.v = en && in_valid;
      cur.a0 = int'(a0); cur.b0 = int'(b0); cur.a1 = int'(a1); cur.b1 = int'(b1);
      cur.s0 = int'(sel0); cur.s1 = int'(sel1);
      q.push_back(cur);
      n_valid = 0; n_o0 = m_o0; n_o1 = m_o1; n_c0 = m_c0; n_c1 = m_c1;
      if (q.size() >= 2) begin
         s = q.pop_front();
         n_valid = s.v;
         if (s.v) begin
            ref_alu(s.a0, s.b0, s.s0, n_o0, n_c0);
            ref_alu(s.a1, s.b1, s.s1, n_o1, n_c1);
         end
      end

      @(posedge clk);
      #1;
      cyc++;
      m_valid = n_valid; m_o0 = n_o0; m_o1 = n_o1; m_c0 = n_c0; m_c1 = n_c1;
      m_err = n_err; m_err_s = n_err_s; m_consec = n_con; m_state = n_state;
      check_all();
      $display("cyc %0d en=%0b clr=%0b iv=%0b | st=%0d ov=%0b o0=%h o1=%h c=%0b%0b mm=%0b err=%0d errs=%0d",
               cyc, en, clr, in_valid, state, out_valid, out0, out1, carry0, carry1,
               mismatch, err_count, err_count_s);
   endtask

   task automatic bubble();
      in_valid = 1'b0;
      step();
   endtask

   // Identical ADD 1+1 on both lanes, or lane 1 off by one when bad=1.
   task automatic send(input bit bad);
      in_valid = 1'b1;
      sel0 = 2'b00; sel1 = 2'b00;
      a0 = 4'h1; b0 = 4'h1; a1 = 4'h1;
      b1 = bad ? 4'h2 : 4'h1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic clear_pulse();
      clr = 1'b1;
      bubble();
      clr = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]   s0, s1;
      logic [W-1:0] a0, b0, a1, b1;
      logic [W-1:0] e_o0, e_o1;
      logic         e_c0, e_c1, e_mm;
      int           e_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      // both ADD F+1: wraps to 0 with carry
      vecs[0] = '{2'b00, 2'b00, 4'hF, 4'h1, 4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 0};
      // SUB 3-5 vs 3-4: borrow on both, results differ by one
      vecs[1] = '{2'b01, 2'b01, 4'h3, 4'h5, 4'h3, 4'h4, 4'hE, 4'hF, 1'b1, 1'b1, 1'b1, 1};
      // AND C&A on both lanes
      vecs[2] = '{2'b10, 2'b10, 4'hC, 4'hA, 4'hC, 4'hA, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0, 1};
      // XOR C^A vs C^B
      vecs[3] = '{2'b11, 2'b11, 4'hC, 4'hA, 4'hC, 4'hB, 4'h6, 4'h7, 1'b0, 1'b0, 1'b1, 2};
      // ADD 7+8 vs SUB 7-8: same result F, carry-only mismatch
      vecs[4] = '{2'b00, 2'b01, 4'h7, 4'h8, 4'h7, 4'h8, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 3};

      rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = '0; sel1 = '0;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_all();                 // reset state: everything zero, IDLE
      rst_n = 1'b1;

      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sel0 = vecs[i].s0; sel1 = vecs[i].s1;
         a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
         in_valid = 1'b1;
         step();
         bubble();                 // result now visible, two cycles after input
         chk("vec_out0",  32'(out0),     32'(vecs[i].e_o0));
         chk("vec_out1",  32'(out1),     32'(vecs[i].e_o1));
         chk("vec_carry", 32'({carry0, carry1}), 32'({vecs[i].e_c0, vecs[i].e_c1}));
         chk("vec_mm",    32'(mismatch), 32'(vecs[i].e_mm));
         chk("vec_valid", 32'(out_valid), 32'd1);
         bubble();
         chk("vec_err",   32'(err_count), 32'(vecs[i].e_err));
      end

      // Three mismatches separated by bubbles -> FAULT after the third
      clear_pulse();
      send(1); bubble(); send(1); bubble(); send(1); bubble(); bubble();
      chk("thresh_fault", 32'(fault), 32'd1);
      chk("thresh_state", 32'(state), 32'd2);

      // en_i low must not leave FAULT
      en = 1'b0; bubble(); bubble(); en = 1'b1;
      chk("fault_hold", 32'(state), 32'd2);

      // clear coincident with a mismatch while faulted, en high -> RUN, err 0
      send(1); bubble();
      chk("clr_mm_pulse", 32'(mismatch), 32'd1);
      clear_pulse();
      chk("clr_state", 32'(state), 32'd1);
      chk("clr_err",   32'(err_count), 32'd0);

      // mismatch, match, mismatch, mismatch -> no fault
      send(1); send(0); send(1); send(1); bubble(); bubble(); bubble();
      chk("nofault_state", 32'(state), 32'd1);
      chk("nofault_err",   32'(err_count), 32'd3);

      // Five mismatches: wide counter reaches 5, CNT_W=2 counter stops at 3
      clear_pulse();
      for (int i = 0; i < 5; i++) send(1);
      bubble(); bubble();
      chk("sat_err",   32'(err_count),   32'd5);
      chk("sat_err_s", 32'(err_count_s), 32'd3);
      clear_pulse();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 9) != 0);
         clr      = ($urandom_range(0, 29) == 0);
         in_valid = ($urandom_range(0, 9) < 7);
         a0 = W'($urandom_range(0, M - 1));
         b0 = W'($urandom_range(0, M - 1));
         sel0 = 2'($urandom_range(0, 3));
         a1 = a0; b1 = b0; sel1 = sel0;
         case ($urandom_range(0, 11))
            0: a1 = W'($urandom_range(0, M - 1));
            1: b1 = W'($urandom_range(0, M - 1));
            2: sel1 = 2'($urandom_range(0, 3));
            default: ;
         endcase
         step();
      end
      en = 1'b1; clr = 1'b0;

      // Reset with two sets in flight: outputs drop at once, nothing leaks out
      clear_pulse();
      send(1); send(1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      bubble(); bubble(); bubble();
      chk("rst_no_valid", 32'(out_valid), 32'd0);
      chk("rst_err",      32'(err_count), 32'd0);
      send(0);
      chk("rst_lat1", 32'(out_valid), 32'd0);
      bubble();
      chk("rst_lat2", 32'(out_valid), 32'd1);
      chk("rst_out",  32'(out0),      32'd2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
